// File: rtl/bpsk_deinterleaver_pkg.sv
// Shared 802.11a PHY constants for the BPSK rate-1/2 deinterleaver.
// It also holds the read-side FSM type and the read-address helper.
package bpsk_deinterleaver_pkg;

    localparam int N_CBPS = 48;
    localparam int N_COL  = 16;
    localparam int N_ROW  = 3;
    localparam int ADDR_W = $clog2(N_COL * N_ROW);

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_t;

    // Bank address holding output bit k: 3*(k mod 16) + floor(k/16), built as (c<<1)+c+row.
    function automatic logic [ADDR_W-1:0] deint_addr(input logic [ADDR_W-1:0] k);
        logic [ADDR_W-1:0] col;
        col = {2'b00, k[3:0]};
        return (col << 1) + col + {4'b0000, k[5:4]};
    endfunction

endpackage

// File: rtl/bpsk_deinterleaver_bank.sv
// 48x1 symbol bank: one synchronous write port and a combinational read port.
// The contents are deliberately not reset.
module deint_bank
    import bpsk_deinterleaver_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic              din,
    input  logic [ADDR_W-1:0] raddr,
    output logic              dout
);

    logic [N_CBPS-1:0] mem_q;
    logic [N_CBPS-1:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = din;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout = mem_q[raddr];

endmodule

// File: rtl/bpsk_deinterleaver.sv
// BPSK 802.11a deinterleaver: ping-pong 48-bit banks on the write side and a
// read FSM that streams each filled bank out as one gap-free 48-cycle burst.
module bpsk_deinterleaver #(
    parameter int N_CBPS = 48
) (
    input  logic Clk,
    input  logic Reset,
    input  logic x,
    input  logic x_valid,
    output logic y,
    output logic Valid,
    output logic sym_start
);

    import bpsk_deinterleaver_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_CBPS - 1);

    logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;
    logic              wr_bank_q, wr_bank_d;
    logic              pend_q, pend_d;
    logic              rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0] k_q, k_d;
    rd_state_t         state_q, state_d;
    logic              y_q, y_d;
    logic              valid_q, valid_d;
    logic              sym_start_q, sym_start_d;

    logic              handoff;
    logic              rd_sel;
    logic [ADDR_W-1:0] raddr;
    logic              dout0, dout1, rd_bit;

    assign handoff = x_valid && (wr_idx_q == LAST_IDX);

    deint_bank u_bank0 (
        .clk   (Clk),
        .we    (x_valid && !wr_bank_q),
        .waddr (wr_idx_q),
        .din   (x),
        .raddr (raddr),
        .dout  (dout0)
    );

    deint_bank u_bank1 (
        .clk   (Clk),
        .we    (x_valid && wr_bank_q),
        .waddr (wr_idx_q),
        .din   (x),
        .raddr (raddr),
        .dout  (dout1)
    );

    always_comb begin
        wr_idx_d  = wr_idx_q;
        wr_bank_d = wr_bank_q;
        if (x_valid) begin
            if (handoff) begin
                wr_idx_d  = '0;
                wr_bank_d = ~wr_bank_q;
            end else begin
                wr_idx_d = wr_idx_q + 1'b1;
            end
        end
    end

    // From IDLE, k=0 is read out of the bank being completed on this very edge;
    // address 0 was written long before, so the same-edge write of bit 47 is harmless.
    always_comb begin
        if (state_q == RD_IDLE) begin
            rd_sel = wr_bank_q;
            raddr  = '0;
        end else begin
            rd_sel = rd_bank_q;
            raddr  = deint_addr(k_q);
        end
    end

    assign rd_bit = rd_sel ? dout1 : dout0;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        rd_bank_d   = rd_bank_q;
        pend_d      = pend_q;
        y_d         = 1'b0;
        valid_d     = 1'b0;
        sym_start_d = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (handoff) begin
                    y_d         = rd_bit;
                    valid_d     = 1'b1;
                    sym_start_d = 1'b1;
                    state_d     = RD_READ;
                    k_d         = 6'd1;
                    rd_bank_d   = wr_bank_q;
                end
            end
            RD_READ: begin
                y_d         = rd_bit;
                valid_d     = 1'b1;
                sym_start_d = (k_q == '0);
                if (k_q == LAST_IDX) begin
                    k_d = '0;
                    if (pend_q || handoff) begin
                        state_d   = RD_READ;
                        rd_bank_d = ~rd_bank_q;
                        pend_d    = 1'b0;
                    end else begin
                        state_d = RD_IDLE;
                    end
                end else begin
                    k_d = k_q + 1'b1;
                    if (handoff) begin
                        pend_d = 1'b1;
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_idx_q    <= '0;
            wr_bank_q   <= 1'b0;
            pend_q      <= 1'b0;
            rd_bank_q   <= 1'b0;
            k_q         <= '0;
            state_q     <= RD_IDLE;
            y_q         <= 1'b0;
            valid_q     <= 1'b0;
            sym_start_q <= 1'b0;
        end else begin
            wr_idx_q    <= wr_idx_d;
            wr_bank_q   <= wr_bank_d;
            pend_q      <= pend_d;
            rd_bank_q   <= rd_bank_d;
            k_q         <= k_d;
            state_q     <= state_d;
            y_q         <= y_d;
            valid_q     <= valid_d;
            sym_start_q <= sym_start_d;
        end
    end

    assign y         = y_q;
    assign Valid     = valid_q;
    assign sym_start = sym_start_q;

endmodule

// File: tb/tb_bpsk_deinterleaver.sv
// Directed bench for bpsk_deinterleaver: single-bit permutations, back-to-back,
// gapped input, mid-burst reset and an interleaver loopback.
module tb_bpsk_deinterleaver;

    logic Clk;
    logic Reset;
    logic x;
    logic x_valid;
    logic y;
    logic Valid;
    logic sym_start;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int bad_idle = 0;

    logic cap_y[$];
    logic cap_s[$];
    int   cap_c[$];

    bpsk_deinterleaver #(.N_CBPS(48)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .x         (x),
        .x_valid   (x_valid),
        .y         (y),
        .Valid     (Valid),
        .sym_start (sym_start)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Output monitor: record every Valid cycle, flag any non-zero output outside bursts.
    always @(posedge Clk) begin
        #1;
        cyc++;
        if (Valid === 1'b1) begin
            cap_y.push_back(y);
            cap_s.push_back(sym_start);
            cap_c.push_back(cyc);
        end else if (y !== 1'b0 || sym_start !== 1'b0 || Valid !== 1'b0) begin
            bad_idle++;
        end
    end

    function automatic logic [47:0] deint_model(input logic [47:0] t);
        logic [47:0] o;
        for (int k = 0; k < 48; k++) o[k] = t[3 * (k % 16) + k / 16];
        return o;
    endfunction

    function automatic logic [47:0] interleave(input logic [47:0] d);
        logic [47:0] t;
        for (int k = 0; k < 48; k++) t[3 * (k % 16) + k / 16] = d[k];
        return t;
    endfunction

    task automatic clear_caps();
        cap_y.delete();
        cap_s.delete();
        cap_c.delete();
    endtask

    task automatic get_sym(input int base, output logic [47:0] v);
        for (int k = 0; k < 48; k++) v[k] = cap_y[base + k];
    endtask

    task automatic send_symbol(input logic [47:0] bits, input int gap, output int last_cyc);
        for (int i = 0; i < 48; i++) begin
            @(negedge Clk);
            x = bits[i];
            x_valid = 1'b1;
            last_cyc = cyc;
            for (int g = 0; g < gap; g++) begin
                @(negedge Clk);
                x_valid = 1'b0;
                x = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        @(negedge Clk);
        x_valid = 1'b0;
        x = 1'b0;
        repeat (n - 1) @(negedge Clk);
    endtask

    task automatic test_reset();
        @(posedge Clk);
        #2;
        checks++;
        if (Valid !== 1'b0 || y !== 1'b0 || sym_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got Valid=%b y=%b sym_start=%b, need 000", Valid, y, sym_start);
        end
        @(negedge Clk);
        Reset = 1'b0;
        clear_caps();
        idle(20);
        checks++;
        if (cap_y.size() != 0) begin
            errors++;
            $display("FAIL reset_no_output: got %0d valid cycles, need 0", cap_y.size());
        end
    endtask

    task automatic test_single_bits();
        int pos[3] = '{3, 47, 1};
        int kexp[3] = '{1, 47, 16};
        int last;
        logic [47:0] stim, got, exp;
        int nstart;
        for (int t = 0; t < 3; t++) begin
            clear_caps();
            stim = 48'd0;
            stim[pos[t]] = 1'b1;
            exp = 48'd0;
            exp[kexp[t]] = 1'b1;
            send_symbol(stim, 0, last);
            idle(60);
            checks++;
            if (cap_y.size() != 48) begin
                errors++;
                $display("FAIL single_count pos=%0d: got %0d valid cycles, need 48", pos[t], cap_y.size());
            end else begin
                get_sym(0, got);
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL single_perm pos=%0d: got %h, need %h", pos[t], got, exp);
                end
                checks++;
                if (cap_c[0] != last + 1 || cap_c[47] - cap_c[0] != 47) begin
                    errors++;
                    $display("FAIL single_timing pos=%0d: first=%0d last=%0d, need first=%0d span=47",
                             pos[t], cap_c[0], cap_c[47], last + 1);
                end
                nstart = 0;
                foreach (cap_s[i]) if (cap_s[i]) nstart++;
                checks++;
                if (nstart != 1 || cap_s[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL single_sym_start pos=%0d: got %0d starts first=%b, need 1 on first",
                             pos[t], nstart, cap_s[0]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [47:0] a, b, got;
        int la, lb;
        int nstart;
        a = 48'hA5C3_0F96_71E8;
        b = 48'h3C5A_E10F_8B27;
        clear_caps();
        send_symbol(a, 0, la);
        send_symbol(b, 0, lb);
        idle(60);
        checks++;
        if (cap_y.size() != 96) begin
            errors++;
            $display("FAIL b2b_count: got %0d valid cycles, need 96", cap_y.size());
        end else begin
            checks++;
            if (cap_c[0] != la + 1 || cap_c[95] - cap_c[0] != 95) begin
                errors++;
                $display("FAIL b2b_contiguous: first=%0d span=%0d, need first=%0d span=95",
                         cap_c[0], cap_c[95] - cap_c[0], la + 1);
            end
            nstart = 0;
            foreach (cap_s[i]) if (cap_s[i]) nstart++;
            checks++;
            if (nstart != 2 || cap_s[0] !== 1'b1 || cap_s[48] !== 1'b1) begin
                errors++;
                $display("FAIL b2b_sym_start: got %0d starts s0=%b s48=%b, need 2 at 0 and 48",
                         nstart, cap_s[0], cap_s[48]);
            end
            get_sym(0, got);
            checks++;
            if (got !== deint_model(a)) begin
                errors++;
                $display("FAIL b2b_sym_a: got %h, need %h", got, deint_model(a));
            end
            get_sym(48, got);
            checks++;
            if (got !== deint_model(b)) begin
                errors++;
                $display("FAIL b2b_sym_b: got %h, need %h", got, deint_model(b));
            end
        end
    endtask

    task automatic test_gapped();
        logic [47:0] a, got;
        int last;
        a = 48'hA5C3_0F96_71E8;
        clear_caps();
        send_symbol(a, 2, last);
        idle(60);
        checks++;
        if (cap_y.size() != 48) begin
            errors++;
            $display("FAIL gapped_count: got %0d valid cycles, need 48", cap_y.size());
        end else begin
            checks++;
            if (cap_c[0] != last + 1 || cap_c[47] - cap_c[0] != 47) begin
                errors++;
                $display("FAIL gapped_contiguous: first=%0d span=%0d, need first=%0d span=47",
                         cap_c[0], cap_c[47] - cap_c[0], last + 1);
            end
            get_sym(0, got);
            checks++;
            if (got !== deint_model(a)) begin
                errors++;
                $display("FAIL gapped_perm: got %h, need %h", got, deint_model(a));
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [47:0] a, b, got;
        int last;
        bit reached;
        a = 48'hFFFF_FFFF_FFFF;
        b = 48'h0123_4567_89AB;
        clear_caps();
        send_symbol(a, 0, last);
        @(negedge Clk);
        x_valid = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge Clk);
            #2;
            if (cap_y.size() >= 21) begin
                reached = 1'b1;
                break;
            end
        end
        checks++;
        if (!reached || Valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_reach: reached=%0d Valid=%b, need burst at k=20", reached, Valid);
        end
        Reset = 1'b1;
        #1;
        checks++;
        if (Valid !== 1'b0 || y !== 1'b0 || sym_start !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_immediate: got Valid=%b y=%b sym_start=%b, need 000", Valid, y, sym_start);
        end
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        clear_caps();
        idle(60);
        checks++;
        if (cap_y.size() != 0) begin
            errors++;
            $display("FAIL rst_mid_stale: got %0d valid cycles after reset, need 0", cap_y.size());
        end
        // A partial symbol followed by reset must be thrown away.
        for (int i = 0; i < 30; i++) begin
            @(negedge Clk);
            x = 1'b1;
            x_valid = 1'b1;
        end
        @(negedge Clk);
        x_valid = 1'b0;
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        clear_caps();
        send_symbol(b, 0, last);
        idle(60);
        checks++;
        if (cap_y.size() != 48) begin
            errors++;
            $display("FAIL rst_resume_count: got %0d valid cycles, need 48", cap_y.size());
        end else begin
            get_sym(0, got);
            checks++;
            if (got !== deint_model(b) || cap_c[0] != last + 1) begin
                errors++;
                $display("FAIL rst_resume_perm: got %h first=%0d, need %h first=%0d",
                         got, cap_c[0], deint_model(b), last + 1);
            end
        end
    endtask

    task automatic test_loopback();
        logic [47:0] data[1000];
        logic [47:0] got;
        int last;
        int bad = 0;
        clear_caps();
        for (int s = 0; s < 1000; s++) begin
            data[s] = {$urandom(), $urandom()};
            send_symbol(interleave(data[s]), 0, last);
        end
        idle(60);
        checks++;
        if (cap_y.size() != 48000 || cap_c[47999] - cap_c[0] != 47999) begin
            errors++;
            $display("FAIL loopback_count: got %0d valid cycles, need 48000 contiguous", cap_y.size());
        end else begin
            for (int s = 0; s < 1000; s++) begin
                get_sym(48 * s, got);
                checks++;
                if (got !== data[s]) begin
                    errors++;
                    if (bad < 5) $display("FAIL loopback_sym %0d: got %h, need %h", s, got, data[s]);
                    bad++;
                end
            end
        end
    endtask

    task automatic test_idle_outputs();
        checks++;
        if (bad_idle != 0) begin
            errors++;
            $display("FAIL idle_outputs: got %0d cycles with y/sym_start set outside bursts, need 0", bad_idle);
        end
    endtask

    initial begin
        Reset = 1'b1;
        x = 1'b0;
        x_valid = 1'b0;
        test_reset();
        test_single_bits();
        test_back_to_back();
        test_gapped();
        test_reset_mid_burst();
        test_loopback();
        test_idle_outputs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
